// File: rtl/friscv_proc_issue_pkg.sv
// Shared definitions for the issue stage: opcodes, instruction bus layout, helpers.
package friscv_proc_issue_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned OPC_W      = 7;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned INST_BUS_W = XLEN + 3 * REG_W + OPC_W;

  localparam logic [OPC_W-1:0] LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] FENCE = 7'b0001111;

  // Decoded instruction bus; field positions are shared with the control unit.
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rd;
    logic [OPC_W-1:0] opcode;
  } inst_bus_t;

  // Number of set bits in the register scoreboard.
  function automatic logic [CNT_W-1:0] popcount32(input logic [NREGS-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/friscv_proc_issue_if.sv
// Handshake bundle between control unit, issue stage, processing stage and memfy.
interface friscv_proc_issue_if;
  import friscv_proc_issue_pkg::*;

  logic                   issue_valid;
  logic                   issue_ready;
  inst_bus_t              issue_instbus;
  logic                   proc_en;
  logic                   proc_ready;
  inst_bus_t              proc_instbus;
  logic                   memfy_rd_wr;
  logic [REG_W-1:0]       memfy_rd_addr;
  logic                   issue_empty;
  logic [CNT_W-1:0]       pending_cnt;

  // Environment side: drives instructions, processing readiness and writebacks.
  modport master (
    output issue_valid, issue_instbus, proc_ready, memfy_rd_wr, memfy_rd_addr,
    input  issue_ready, proc_en, proc_instbus, issue_empty, pending_cnt
  );

  // Issue stage side.
  modport slave (
    input  issue_valid, issue_instbus, proc_ready, memfy_rd_wr, memfy_rd_addr,
    output issue_ready, proc_en, proc_instbus, issue_empty, pending_cnt
  );
endinterface

// File: rtl/friscv_issue_fifo.sv
// Generic synchronous FIFO with full/empty/count; head reads as zero when empty.
module friscv_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         srst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [W-1:0]                 i_data,
  output logic [W-1:0]                 o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; pointers wrap at the power-of-two depth.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents beyond the occupied window are don't-care.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/friscv_proc_issue.sv
// Issue stage: in-order FIFO dispatch gated by a load scoreboard and FENCE drain.
module friscv_proc_issue
  import friscv_proc_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  friscv_proc_issue_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [INST_BUS_W-1:0] w_fifo_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CW-1:0]         w_fifo_count;
  inst_bus_t             w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_hazard;
  logic                  w_set;
  logic [NREGS-1:0]      r_pending;
  logic [NREGS-1:0]      w_pending_nxt;

  friscv_issue_fifo #(
    .DEPTH (DEPTH),
    .W     (INST_BUS_W)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.issue_instbus),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_head            = inst_bus_t'(w_fifo_data);
  assign bus.issue_ready   = ~w_fifo_full;
  assign w_push            = bus.issue_valid & bus.issue_ready;
  assign w_pop             = bus.proc_en & bus.proc_ready;
  assign bus.proc_instbus  = w_head;
  assign bus.proc_en       = ~w_fifo_empty & ~w_hazard;
  assign bus.issue_empty   = (w_fifo_count == '0) & (r_pending == '0);
  assign bus.pending_cnt   = popcount32(r_pending);
  assign w_set             = w_pop & (w_head.opcode == LOAD) & (w_head.rd != '0);

  // Head hazard: any operand with an outstanding load, or FENCE with loads in flight.
  always_comb begin
    w_hazard = 1'b0;
    if ((w_head.rs1 != '0) && r_pending[w_head.rs1]) w_hazard = 1'b1;
    if ((w_head.rs2 != '0) && r_pending[w_head.rs2]) w_hazard = 1'b1;
    if ((w_head.rd  != '0) && r_pending[w_head.rd])  w_hazard = 1'b1;
    if ((w_head.opcode == FENCE) && (r_pending != '0)) w_hazard = 1'b1;
  end

  // Scoreboard update: clear applied first so a same-index set wins; x0 never pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.memfy_rd_wr) w_pending_nxt[bus.memfy_rd_addr] = 1'b0;
    if (w_set)           w_pending_nxt[w_head.rd]         = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pending <= '0;
    end else if (srst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

endmodule
